// File: rtl/systolic_ctrl.sv
// systolic_ctrl: 3x3 systolic array sequencer (stream in A/B, clear, run, stream out C).
// Define SYSTOLIC_CTRL_TIMEOUT_EN to add a RUN watchdog driving err_o.
module systolic_ctrl #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [15:0]  out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err_o,
    output logic         arr_rst,
    output logic         arr_start,
    output logic [71:0]  arr_a,
    output logic [71:0]  arr_b,
    input  logic [143:0] arr_c,
    input  logic         arr_done
);
    typedef enum logic [1:0] {LOAD, CLEAR, RUN, DRAIN} state_t;
    state_t state_q, state_d;
    logic [4:0] ld_cnt_q, ld_cnt_d;
    logic [3:0] dr_cnt_q, dr_cnt_d;
    logic [7:0] op_q [18];
    logic [15:0] res_q [9];
    logic arr_rst_q, arr_start_q, out_valid_q, out_last_q, busy_q;
    logic accept, xfer, timeout, finish;

    assign in_ready  = state_q == LOAD;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid_q && out_ready;
    assign finish    = state_q == RUN && (arr_done || timeout);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign arr_rst   = arr_rst_q;
    assign arr_start = arr_start_q;
    assign out_data  = res_q[dr_cnt_q];

    genvar k;
    for (k = 0; k < 9; k++) begin : g_ops
        assign arr_a[8*k +: 8] = op_q[k];
        assign arr_b[8*k +: 8] = op_q[9+k];
    end

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] run_cnt_q;
    logic err_q;
    assign timeout = state_q == RUN && !arr_done && run_cnt_q == T_LAST;
    assign err_o   = err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            run_cnt_q <= state_q == RUN ? run_cnt_q + 1'b1 : '0;
            err_q     <= timeout ? 1'b1 : accept ? 1'b0 : err_q;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        dr_cnt_d = dr_cnt_q;
        case (state_q)
            LOAD: if (accept) begin
                ld_cnt_d = ld_cnt_q == 5'd17 ? 5'd0 : ld_cnt_q + 5'd1;
                state_d  = ld_cnt_q == 5'd17 ? CLEAR : LOAD;
            end
            CLEAR: state_d = RUN;
            RUN:   state_d = finish ? DRAIN : RUN;
            DRAIN: if (xfer) begin
                dr_cnt_d = dr_cnt_q == 4'd8 ? 4'd0 : dr_cnt_q + 4'd1;
                state_d  = dr_cnt_q == 4'd8 ? LOAD : DRAIN;
            end
            default: state_d = LOAD;
        endcase
    end

    // Array-facing and stream flags are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            ld_cnt_q    <= '0;
            dr_cnt_q    <= '0;
            arr_rst_q   <= 1'b1;
            arr_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_cnt_q    <= ld_cnt_d;
            dr_cnt_q    <= dr_cnt_d;
            arr_rst_q   <= state_d == CLEAR;
            arr_start_q <= state_d == RUN;
            out_valid_q <= state_d == DRAIN;
            out_last_q  <= state_d == DRAIN && dr_cnt_d == 4'd8;
            busy_q      <= state_d != LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 18; i++) op_q[i] <= '0;
            for (int i = 0; i < 9; i++) res_q[i] <= '0;
        end else begin
            if (accept) op_q[ld_cnt_q] <= in_data;
            if (finish)
                for (int i = 0; i < 9; i++) res_q[i] <= arr_done ? arr_c[16*i +: 16] : 16'd0;
        end
    end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: randomized job stream with a behavioural array and matrix-product reference.
module tb_systolic_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [7:0]   in_data = '0;
    logic         out_valid, out_ready = 1'b0, out_last, busy, err_o;
    logic [15:0]  out_data;
    logic         arr_rst, arr_start;
    logic [71:0]  arr_a, arr_b;
    logic [143:0] arr_c = '0;
    logic         arr_done = 1'b0;
    logic         hang = 1'b0;
    int           acnt = 0;
    int           ncyc = 0, t0 = 0, clr_cnt = 0;
    int           n_chk = 0, n_fail = 0;
    logic [7:0]   ops [18];
    logic [15:0]  expq [9];

    systolic_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err_o(err_o), .arr_rst(arr_rst), .arr_start(arr_start),
        .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c), .arr_done(arr_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Array stand-in: nine start-high edges after a clear, then sticky done with C = A*B.
    function automatic logic [143:0] mm(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] c;
        logic [15:0] s;
        c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int m = 0; m < 3; m++) s += 16'(a[8*(3*i+m) +: 8]) * 16'(b[8*(3*m+j) +: 8]);
                c[16*(3*i+j) +: 16] = s;
            end
        return c;
    endfunction

    always @(posedge clk) begin
        if (arr_rst) begin
            acnt     <= 0;
            arr_done <= 1'b0;
        end else if (arr_start && !arr_done && !hang) begin
            acnt <= acnt + 1;
            if (acnt == 8) begin
                arr_done <= 1'b1;
                arr_c    <= mm(arr_a, arr_b);
            end
        end
    end

    always @(negedge clk)
        if (rst && arr_rst) begin
            clr_cnt++;
            chk("clr_start_low", arr_start, 0);
        end

    task automatic ref_model();
        int s;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int m = 0; m < 3; m++) s += int'(ops[3*i+m]) * int'(ops[9+3*m+j]);
                expq[3*i+j] = 16'(s % 65536);
            end
    endtask

    task automatic load_ops(input bit rnd);
        int idx = 0, g = 0;
        bit hs;
        while (idx < 18 && g < 300) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = ops[idx];
            hs = in_valid && in_ready;
            if (hs && idx == 0) t0 = ncyc;
            @(negedge clk);
            g++;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        chk("loaded", idx, 18);
    endtask

    task automatic drain_chk(input bit rnd, input bit lat);
        int beat = 0, g = 0;
        bit hs, st, seen = 0;
        logic [15:0] held = '0;
        while (beat < 9 && g < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = 0;
            st = 0;
            if (out_valid) begin
                if (!seen && lat) chk("latency", ncyc - t0, 29);
                seen = 1;
                chk("data", out_data, expq[beat]);
                chk("last", out_last, beat == 8);
                chk("busy", busy, 1);
                hs = out_ready;
                st = !out_ready;
                held = out_data;
            end
            @(negedge clk);
            g++;
            if (st) chk("hold", out_data, held);
            if (hs) beat++;
        end
        out_ready = 1'b0;
        chk("drained", beat, 9);
        chk("next_load", in_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic job(input bit rnd, input bit lat);
        ref_model();
        clr_cnt = 0;
        load_ops(rnd);
        drain_chk(rnd, lat);
        chk("clr_pulses", clr_cnt, 1);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 18; i++) ops[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_arr_rst", arr_rst, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_o, 0);
        chk("rst_arr_start", arr_start, 0);
        chk("rst_arr_a", 32'(arr_a != 0), 0);
        chk("rst_arr_b", 32'(arr_b != 0), 0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rel_arr_rst", arr_rst, 0);

        for (int i = 0; i < 9; i++) begin
            ops[i] = 8'(i + 1);
            ops[9+i] = (i % 4 == 0) ? 8'd1 : 8'd0;
        end
        job(0, 1);
        for (int i = 0; i < 9; i++) chk("identity_ref", expq[i], i + 1);

        for (int i = 0; i < 9; i++) begin
            ops[i] = 8'(i + 1);
            ops[9+i] = 8'(i + 1);
        end
        job(0, 1);
        chk("square_c1", expq[0], 30);
        chk("square_c9", expq[8], 150);

        for (int i = 0; i < 18; i++) ops[i] = 8'd255;
        job(0, 1);
        chk("overflow_c5", expq[4], 64003);

        rand_ops();
        job(1, 0);
        rand_ops();
        job(1, 0);

        rand_ops();
        load_ops(0);
        for (int g = 0; g < 50 && !arr_start; g++) @(negedge clk);
        chk("run_reached", arr_start, 1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_arr_start", arr_start, 0);
        chk("mid_arr_rst", arr_rst, 1);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rand_ops();
        job(1, 0);
        chk("err_idle", err_o, 0);

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
        rand_ops();
        hang = 1'b1;
        load_ops(0);
        for (int i = 0; i < 9; i++) expq[i] = '0;
        drain_chk(0, 0);
        chk("err_set", err_o, 1);
        hang = 1'b0;
        rand_ops();
        ref_model();
        load_ops(0);
        chk("err_clr", err_o, 0);
        drain_chk(0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=%0d exp=%0d", ncyc, 0);
        $fatal(1, "watchdog");
    end
endmodule
